alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/alu_seq_core.sv | 81 ++++++++
 rtl/alu_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and helpers for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_SAR  = 4'hA;
  localparam logic [3:0] OP_ROL  = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_DEC  = 4'hD;
  localparam logic [3:0] OP_PASS = 4'hE;
  localparam logic [3:0] OP_CMP  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational add/sub/logic unit with carry, overflow and zero flags.
// Shift opcodes fall through with res = a and no carry update.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             cupd_o
);

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] addb, subb;
  logic             addc, subc;
  logic [WIDTH:0]   sum, dif;
  logic             add_v, sub_v;

  always_comb begin
    addb = b_i;
    subb = b_i;
    addc = 1'b0;
    subc = 1'b0;
    unique case (op_i)
      OP_ADC:  addc = cin_i;
      OP_SBB:  subc = cin_i;
      OP_INC:  addb = ONE;
      OP_DEC:  subb = ONE;
      default: ;
    endcase
  end

  // Borrow is the top bit of the widened difference.
  assign sum   = {1'b0, a_i} + {1'b0, addb} + {{WIDTH{1'b0}}, addc};
  assign dif   = {1'b0, a_i} - {1'b0, subb} - {{WIDTH{1'b0}}, subc};
  assign add_v = (a_i[M] == addb[M]) && (sum[M] != a_i[M]);
  assign sub_v = (a_i[M] != subb[M]) && (dif[M] != a_i[M]);

  always_comb begin
    res_o  = a_i;
    cout_o = cin_i;
    ovf_o  = 1'b0;
    cupd_o = 1'b0;
    unique case (op_i)
      OP_ADD, OP_ADC, OP_INC: begin
        res_o  = sum[M:0];
        cout_o = sum[WIDTH];
        ovf_o  = add_v;
        cupd_o = 1'b1;
      end
      OP_SUB, OP_SBB, OP_DEC: begin
        res_o  = dif[M:0];
        cout_o = dif[WIDTH];
        ovf_o  = sub_v;
        cupd_o = 1'b1;
      end
      OP_CMP: begin
        cout_o = dif[WIDTH];
        ovf_o  = sub_v;
        cupd_o = 1'b1;
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NAND: res_o = ~(a_i & b_i);
      OP_PASS: res_o = b_i;
      default: ;
    endcase
  end

  assign zero_o = (op_i == OP_CMP) ? (a_i == b_i) : (res_o == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one-cycle arithmetic/logic, bit-serial shifts,
// valid/ready handshake on both sides.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             equals_zero,
  output logic             overflow,
  output logic             carry,
  output logic             busy
);

  localparam int SHAMT_W = clog2(WIDTH);

  state_e               state_q, state_d;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     sh_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q, ovf_q, carry_q;

  logic                 accept, shift_op, last;
  logic [SHAMT_W-1:0]   amt;
  logic [WIDTH-1:0]     step_v;
  logic                 step_bit;
  logic [WIDTH-1:0]     core_res;
  logic                 core_cout, core_ovf, core_zero, core_cupd;

  assign accept   = in_valid && in_ready;
  assign amt      = op2[SHAMT_W-1:0];
  assign shift_op = is_shift(opcode);
  assign last     = cnt_q == SHAMT_W'(1);

  alu_seq_core #(.WIDTH(WIDTH)) u_core (
    .op_i   (opcode),
    .a_i    (op1),
    .b_i    (op2),
    .cin_i  (carry_q),
    .res_o  (core_res),
    .cout_o (core_cout),
    .ovf_o  (core_ovf),
    .zero_o (core_zero),
    .cupd_o (core_cupd)
  );

  // One bit position per cycle; rol keeps the carry as-is.
  always_comb begin
    step_v   = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
    step_bit = carry_q;
    unique case (op_q)
      OP_SHL: begin
        step_v   = {sh_q[WIDTH-2:0], 1'b0};
        step_bit = sh_q[WIDTH-1];
      end
      OP_SHR: begin
        step_v   = {1'b0, sh_q[WIDTH-1:1]};
        step_bit = sh_q[0];
      end
      OP_SAR: begin
        step_v   = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        step_bit = sh_q[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = (shift_op && amt != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: if (last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == S_IDLE;
    out_valid = state_q == S_DONE;
    busy      = state_q != S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      op_q  <= opcode;
      sh_q  <= op1;
      cnt_q <= amt;
      if (!shift_op) begin
        result_q <= core_res;
        zero_q   <= core_zero;
        ovf_q    <= core_ovf;
        if (core_cupd) carry_q <= core_cout;
      end else if (amt == '0) begin
        result_q <= op1;
        zero_q   <= op1 == '0;
        ovf_q    <= 1'b0;
      end
    end else if (state_q == S_SHIFT) begin
      sh_q  <= step_v;
      cnt_q <= cnt_q - SHAMT_W'(1);
      if (last) begin
        result_q <= step_v;
        zero_q   <= step_v == '0;
        ovf_q    <= 1'b0;
        if (op_q != OP_ROL) carry_q <= step_bit;
      end
    end
  end

  assign result      = result_q;
  assign equals_zero = zero_q;
  assign overflow    = ovf_q;
  assign carry       = carry_q;

endmodule
